// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM encoding and opcode decode for the ALU issue arbiter.
// Consumed by alu_req_arbiter and alu_issue_arbiter.
package alu_ctrl_pkg;

    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] BR_NONE = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // The ALU only implements this subset; anything else is returned as an error.
    function automatic logic op_supported(input logic [6:0] opc,
                                          input logic [2:0] f3,
                                          input logic [6:0] f7);
        logic ok;
        ok = 1'b0;
        case (opc)
            OP_ITYPE: ok = (f3 == 3'b000) || ((f3 == 3'b001) && (f7 == 7'b0000000));
            OP_RTYPE: begin
                case (f3)
                    3'b000:                      ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    3'b001, 3'b100, 3'b110, 3'b111: ok = (f7 == 7'b0000000);
                    3'b101:                      ok = (f7 == 7'b0100000);
                    default:                     ok = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE: ok = (f3 == 3'b011);
            OP_BRANCH: ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_req_arbiter.sv
// One-hot request arbiter. ALU_ARB_RR_EN selects round-robin from a pointer;
// otherwise fixed priority with the lowest index winning.
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = 1
) (
    input  logic [N_REQ-1:0] req_valid,
`ifdef ALU_ARB_RR_EN
    input  logic [IDW-1:0]   ptr,
`endif
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_id,
    output logic             grant_any
);

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
`ifdef ALU_ARB_RR_EN
        // Visit requesters in order ptr, ptr+1, ... wrapping; first valid wins.
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_any && req_valid[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
                    grant[i]  = 1'b1;
                    grant_id  = IDW'(i);
                    grant_any = 1'b1;
                end
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant[i]  = 1'b1;
                grant_id  = IDW'(i);
                grant_any = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one registered-latency ALU between N_REQ requesters, one op in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module alu_issue_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int XLEN  = 64,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*7-1:0]    req_opcode,
    input  logic [N_REQ*3-1:0]    req_func3,
    input  logic [N_REQ*7-1:0]    req_func7,
    input  logic [N_REQ*XLEN-1:0] req_a,
    input  logic [N_REQ*XLEN-1:0] req_b,
    input  logic [N_REQ*XLEN-1:0] req_branch_input,
    output logic [6:0]            alu_opcode,
    output logic [2:0]            alu_func3,
    output logic [6:0]            alu_func7,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [XLEN-1:0]       alu_branch_input,
    input  logic [XLEN-1:0]       alu_out,
    input  logic [2:0]            alu_branch_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [XLEN-1:0]       rsp_out,
    output logic [2:0]            rsp_branch_sel,
    output logic                  rsp_err
);

    logic [6:0]      opc_arr [N_REQ];
    logic [2:0]      f3_arr  [N_REQ];
    logic [6:0]      f7_arr  [N_REQ];
    logic [XLEN-1:0] a_arr   [N_REQ];
    logic [XLEN-1:0] b_arr   [N_REQ];
    logic [XLEN-1:0] bi_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign opc_arr[gi] = req_opcode[gi*7 +: 7];
            assign f3_arr[gi]  = req_func3[gi*3 +: 3];
            assign f7_arr[gi]  = req_func7[gi*7 +: 7];
            assign a_arr[gi]   = req_a[gi*XLEN +: XLEN];
            assign b_arr[gi]   = req_b[gi*XLEN +: XLEN];
            assign bi_arr[gi]  = req_branch_input[gi*XLEN +: XLEN];
        end
    endgenerate

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            err_q, err_d;
    logic [6:0]      alu_opcode_q, alu_opcode_d;
    logic [2:0]      alu_func3_q, alu_func3_d;
    logic [6:0]      alu_func7_q, alu_func7_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [XLEN-1:0] alu_bi_q, alu_bi_d;
    logic [XLEN-1:0] rsp_out_q, rsp_out_d;
    logic [2:0]      rsp_sel_q, rsp_sel_d;
    logic            rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic             sel_ok;

`ifdef ALU_ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;
`endif

    alu_req_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req_valid (req_valid),
`ifdef ALU_ARB_RR_EN
        .ptr       (ptr_q),
`endif
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign sel_ok = op_supported(opc_arr[grant_id], f3_arr[grant_id], f7_arr[grant_id]);

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        err_d        = err_q;
        alu_opcode_d = alu_opcode_q;
        alu_func3_d  = alu_func3_q;
        alu_func7_d  = alu_func7_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_bi_d     = alu_bi_q;
        rsp_out_d    = rsp_out_q;
        rsp_sel_d    = rsp_sel_q;
        rsp_err_d    = rsp_err_q;
`ifdef ALU_ARB_RR_EN
        ptr_d        = ptr_q;
`endif
        // Gated by rst so nothing looks accepted while reset is held.
        req_ready    = (state_q == IDLE && !rst) ? grant : '0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d      = EXEC;
                    id_d         = grant_id;
                    err_d        = !sel_ok;
                    alu_opcode_d = sel_ok ? opc_arr[grant_id] : 7'b0;
                    alu_func3_d  = f3_arr[grant_id];
                    alu_func7_d  = f7_arr[grant_id];
                    alu_a_d      = a_arr[grant_id];
                    alu_b_d      = b_arr[grant_id];
                    alu_bi_d     = bi_arr[grant_id];
`ifdef ALU_ARB_RR_EN
                    ptr_d        = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
`endif
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                rsp_out_d = err_q ? '0 : alu_out;
                rsp_sel_d = (!err_q && alu_opcode_q == OP_BRANCH) ? alu_branch_sel : BR_NONE;
                rsp_err_d = err_q;
                // Park the ALU bus at zero so stale operands cannot retrigger it.
                alu_opcode_d = '0;
                alu_func3_d  = '0;
                alu_func7_d  = '0;
                alu_a_d      = '0;
                alu_b_d      = '0;
                alu_bi_d     = '0;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            err_q        <= 1'b0;
            alu_opcode_q <= '0;
            alu_func3_q  <= '0;
            alu_func7_q  <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_bi_q     <= '0;
            rsp_out_q    <= '0;
            rsp_sel_q    <= BR_NONE;
            rsp_err_q    <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            err_q        <= err_d;
            alu_opcode_q <= alu_opcode_d;
            alu_func3_q  <= alu_func3_d;
            alu_func7_q  <= alu_func7_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_bi_q     <= alu_bi_d;
            rsp_out_q    <= rsp_out_d;
            rsp_sel_q    <= rsp_sel_d;
            rsp_err_q    <= rsp_err_d;
`ifdef ALU_ARB_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign alu_opcode       = alu_opcode_q;
    assign alu_func3        = alu_func3_q;
    assign alu_func7        = alu_func7_q;
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_branch_input = alu_bi_q;
    assign rsp_valid        = (state_q == RESP);
    assign rsp_id           = id_q;
    assign rsp_out          = rsp_out_q;
    assign rsp_branch_sel   = rsp_sel_q;
    assign rsp_err          = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter with a behavioural registered ALU.
// Grant-order expectations follow ALU_ARB_RR_EN.
module tb_alu_issue_arbiter;
    import alu_ctrl_pkg::*;

    localparam int N_REQ = 2;
    localparam int XLEN  = 64;
    localparam int IDW   = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]      req_valid, req_ready;
    logic [N_REQ*7-1:0]    req_opcode, req_func7;
    logic [N_REQ*3-1:0]    req_func3;
    logic [N_REQ*XLEN-1:0] req_a, req_b, req_branch_input;
    logic [6:0]            alu_opcode, alu_func7;
    logic [2:0]            alu_func3;
    logic [XLEN-1:0]       alu_a, alu_b, alu_branch_input;
    logic [XLEN-1:0]       m_out;
    logic [2:0]            m_sel;
    logic                  rsp_valid, rsp_ready, rsp_err;
    logic [IDW-1:0]        rsp_id;
    logic [XLEN-1:0]       rsp_out;
    logic [2:0]            rsp_branch_sel;

    alu_issue_arbiter #(.N_REQ(N_REQ), .XLEN(XLEN), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_func3(req_func3), .req_func7(req_func7),
        .req_a(req_a), .req_b(req_b), .req_branch_input(req_branch_input),
        .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func7(alu_func7),
        .alu_a(alu_a), .alu_b(alu_b), .alu_branch_input(alu_branch_input),
        .alu_out(m_out), .alu_branch_sel(m_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_branch_sel(rsp_branch_sel), .rsp_err(rsp_err)
    );

    // Registered ALU: computes on the edge, holds when opcode is zero.
    always @(posedge clk) begin
        case (alu_opcode)
            OP_ITYPE: begin
                m_out <= (alu_func3 == 3'b001) ? (alu_a << alu_b[5:0]) : (alu_a + alu_b);
                m_sel <= BR_NONE;
            end
            OP_RTYPE: begin
                m_sel <= BR_NONE;
                case (alu_func3)
                    3'b000:  m_out <= alu_func7[5] ? (alu_a - alu_b) : (alu_a + alu_b);
                    3'b001:  m_out <= alu_a << alu_b[5:0];
                    3'b100:  m_out <= alu_a ^ alu_b;
                    3'b101:  m_out <= XLEN'($signed(alu_a) >>> alu_b[5:0]);
                    3'b110:  m_out <= alu_a | alu_b;
                    3'b111:  m_out <= alu_a & alu_b;
                    default: m_out <= '0;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                m_out <= alu_a + alu_b;
                m_sel <= BR_NONE;
            end
            OP_BRANCH: begin
                m_out <= alu_a - alu_b;
                case (alu_func3)
                    3'b000:  m_sel <= (alu_a == alu_b) ? 3'b000 : BR_NONE;
                    3'b001:  m_sel <= (alu_a != alu_b) ? 3'b001 : BR_NONE;
                    3'b100:  m_sel <= ($signed(alu_a) <  $signed(alu_b)) ? 3'b010 : BR_NONE;
                    3'b101:  m_sel <= ($signed(alu_a) >= $signed(alu_b)) ? 3'b011 : BR_NONE;
                    default: m_sel <= BR_NONE;
                endcase
            end
            default: ;
        endcase
    end

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [XLEN-1:0] out;
        logic [2:0]      sel;
        logic            err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_rsp(input int id, input logic [XLEN-1:0] out,
                                       input logic [2:0] sel, input logic err);
        rsp_t e;
        e.id = IDW'(id); e.out = out; e.sel = sel; e.err = err;
        exp_q.push_back(e);
    endfunction

    // Response scoreboard: one line per completed response handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rsp: got id=%0d out=%h sel=%b err=%b, expected none",
                         rsp_id, rsp_out, rsp_branch_sel, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_id, rsp_out, rsp_branch_sel, rsp_err} !== mon_e) begin
                    miscompares++;
                    $display("FAIL rsp: got id=%0d out=%h sel=%b err=%b, expected id=%0d out=%h sel=%b err=%b",
                             rsp_id, rsp_out, rsp_branch_sel, rsp_err,
                             mon_e.id, mon_e.out, mon_e.sel, mon_e.err);
                end else begin
                    $display("rsp id=%0d out=%h sel=%b err=%b", rsp_id, rsp_out, rsp_branch_sel, rsp_err);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] bi);
        req_valid[i]                  = 1'b1;
        req_opcode[i*7 +: 7]          = opc;
        req_func3[i*3 +: 3]           = f3;
        req_func7[i*7 +: 7]           = f7;
        req_a[i*XLEN +: XLEN]         = a;
        req_b[i*XLEN +: XLEN]         = b;
        req_branch_input[i*XLEN +: XLEN] = bi;
    endtask

    // Holds request i until accepted; returns the cycle in which req_ready was seen.
    task automatic issue(input int i, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] bi,
                         output int acc_cyc);
        set_req(i, opc, f3, f7, a, b, bi);
        acc_cyc = -1;
        for (int n = 0; n < 60 && acc_cyc < 0; n++) begin
            @(negedge clk);
            if (req_ready[i]) acc_cyc = cyc;
        end
        if (acc_cyc < 0) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: req%0d req_ready never 1", i);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rsp_ready = 1'b1;
        req_valid = '0; req_opcode = '0; req_func3 = '0; req_func7 = '0;
        req_a = '0; req_b = '0; req_branch_input = '0;
        #1 rst = 1'b1;
        set_req(0, OP_ITYPE, 3'b000, 7'b0, 64'd1, 64'd1, 64'd0);
        set_req(1, OP_ITYPE, 3'b000, 7'b0, 64'd2, 64'd2, 64'd0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b, expected 00", req_ready); end
        vectors++;
        if ({alu_opcode, alu_func3, alu_func7, alu_a, alu_b, alu_branch_input} !== '0) begin
            miscompares++; $display("FAIL reset_alu_bus: got opcode=%b a=%h b=%h, expected all 0", alu_opcode, alu_a, alu_b);
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_out, rsp_branch_sel, rsp_err} !== {1'b0, 1'b0, 64'd0, 3'b111, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_rsp: got valid=%b id=%0d out=%h sel=%b err=%b, expected 0 0 0 111 0",
                     rsp_valid, rsp_id, rsp_out, rsp_branch_sel, rsp_err);
        end
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int t_acc, t_rsp;
        expect_rsp(0, 64'd12, 3'b111, 1'b0);
        issue(0, OP_ITYPE, 3'b000, 7'b0, 64'd5, 64'd7, 64'd0, t_acc);
        vectors++;
        if ({alu_opcode, alu_a, alu_b} !== {OP_ITYPE, 64'd5, 64'd7}) begin
            miscompares++; $display("FAIL exec_bus: got opcode=%b a=%0d b=%0d, expected 0010011 5 7", alu_opcode, alu_a, alu_b);
        end
        t_rsp = -1;
        for (int n = 0; n < 20 && t_rsp < 0; n++) begin
            @(negedge clk);
            if (rsp_valid) t_rsp = cyc;
        end
        vectors++;
        if (t_rsp - t_acc !== 3) begin
            miscompares++; $display("FAIL latency: got %0d cycles, expected 3", t_rsp - t_acc);
        end
        drain();
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rsp_valid_drop: got %b, expected 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int nxt[2];
        int order[$];
        int exp_order[8];
        logic [N_REQ-1:0] acc;
        do_reset();
        rsp_ready = 1'b1;
`ifdef ALU_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        for (int k = 0; k < 4; k++) nxt[0] = 0;
        nxt[0] = 0; nxt[1] = 0;
        for (int n = 0; n < 8; n++) begin
            int r = exp_order[n];
            int k = 0;
            for (int m = 0; m < n; m++) if (exp_order[m] == r) k++;
            expect_rsp(r, 64'(100 * (r + 1) + k + 1), 3'b111, 1'b0);
        end
        set_req(0, OP_ITYPE, 3'b000, 7'b0, 64'd100, 64'd1, 64'd0);
        set_req(1, OP_ITYPE, 3'b000, 7'b0, 64'd200, 64'd1, 64'd0);
        for (int n = 0; n < 200 && (nxt[0] < 4 || nxt[1] < 4); n++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (acc != '0) begin
                vectors++;
                if ($countones(req_ready) != 1) begin
                    miscompares++; $display("FAIL onehot_ready: got %b, expected one-hot", req_ready);
                end
                order.push_back(acc[1] ? 1 : 0);
            end
            @(posedge clk); #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc[i]) begin
                    nxt[i]++;
                    if (nxt[i] < 4) set_req(i, OP_ITYPE, 3'b000, 7'b0, 64'(100 * (i + 1) + nxt[i]), 64'd1, 64'd0);
                    else req_valid[i] = 1'b0;
                end
            end
        end
        vectors++;
        if (order.size() != 8) begin
            miscompares++; $display("FAIL grant_count: got %0d, expected 8", order.size());
        end else begin
            for (int n = 0; n < 8; n++) begin
                vectors++;
                if (order[n] != exp_order[n]) begin
                    miscompares++; $display("FAIL grant_order[%0d]: got %0d, expected %0d", n, order[n], exp_order[n]);
                end
            end
        end
        drain();
    endtask

    task automatic test_branch();
        int t;
        rsp_ready = 1'b1;
        expect_rsp(1, 64'd0, 3'b000, 1'b0);
        expect_rsp(1, 64'd0, 3'b111, 1'b0);
        expect_rsp(1, 64'd18, 3'b111, 1'b0);
        expect_rsp(1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 1'b0);
        issue(1, OP_BRANCH, 3'b000, 7'b0, 64'd9, 64'd9, 64'd9, t);
        issue(1, OP_BRANCH, 3'b001, 7'b0, 64'd9, 64'd9, 64'd9, t);
        issue(1, OP_RTYPE,  3'b000, 7'b0, 64'd9, 64'd9, 64'd9, t);
        issue(1, OP_BRANCH, 3'b100, 7'b0, 64'd3, 64'd5, 64'd0, t);
        drain();
    endtask

    task automatic test_alu_ops();
        int t;
        rsp_ready = 1'b1;
        expect_rsp(0, 64'd7, 3'b111, 1'b0);
        expect_rsp(0, 64'hFFFF_FFFF_FFFF_FFFC, 3'b111, 1'b0);
        expect_rsp(0, 64'd16, 3'b111, 1'b0);
        expect_rsp(1, 64'd108, 3'b111, 1'b0);
        expect_rsp(1, 64'd0, 3'b111, 1'b1);
        issue(0, OP_RTYPE, 3'b000, 7'b0100000, 64'd10, 64'd3, 64'd0, t);
        issue(0, OP_RTYPE, 3'b101, 7'b0100000, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'd0, t);
        issue(0, OP_ITYPE, 3'b001, 7'b0, 64'd1, 64'd4, 64'd0, t);
        issue(1, OP_LOAD,  3'b011, 7'b0, 64'd100, 64'd8, 64'd0, t);
        issue(1, OP_LOAD,  3'b010, 7'b0, 64'd100, 64'd8, 64'd0, t);
        drain();
    endtask

    task automatic test_backpressure();
        int t;
        rsp_ready = 1'b0;
        expect_rsp(0, 64'd42, 3'b111, 1'b0);
        expect_rsp(1, 64'hFF, 3'b111, 1'b0);
        issue(0, OP_RTYPE, 3'b000, 7'b0, 64'd20, 64'd22, 64'd0, t);
        set_req(1, OP_RTYPE, 3'b100, 7'b0, 64'hF0, 64'h0F, 64'd0);
        t = -1;
        for (int n = 0; n < 20 && t < 0; n++) begin
            @(negedge clk);
            if (rsp_valid) t = cyc;
        end
        for (int n = 0; n < 5; n++) begin
            if (n != 0) @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_id, rsp_out, req_ready} !== {1'b1, 1'b0, 64'd42, 2'b00}) begin
                miscompares++;
                $display("FAIL stall[%0d]: got valid=%b id=%0d out=%0d req_ready=%b, expected 1 0 42 00",
                         n, rsp_valid, rsp_id, rsp_out, req_ready);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        issue(1, OP_RTYPE, 3'b100, 7'b0, 64'hF0, 64'h0F, 64'd0, t);
        drain();
    endtask

    task automatic test_err();
        int t;
        rsp_ready = 1'b1;
        expect_rsp(0, 64'd0, 3'b111, 1'b1);
        issue(0, OP_RTYPE, 3'b100, 7'b0100000, 64'd3, 64'd4, 64'd0, t);
        vectors++;
        if (alu_opcode !== 7'b0) begin miscompares++; $display("FAIL err_exec_opcode: got %b, expected 0", alu_opcode); end
        @(posedge clk); #1;
        vectors++;
        if (alu_opcode !== 7'b0) begin miscompares++; $display("FAIL err_capt_opcode: got %b, expected 0", alu_opcode); end
        drain();
    endtask

    task automatic test_reset_in_capt();
        int t;
        rsp_ready = 1'b1;
        issue(0, OP_ITYPE, 3'b000, 7'b0, 64'd1, 64'd2, 64'd0, t);
        @(posedge clk); #2;
        rst = 1'b1;
        set_req(1, OP_ITYPE, 3'b000, 7'b0, 64'd5, 64'd5, 64'd0);
        #1;
        vectors++;
        if ({alu_opcode, alu_a, alu_b, req_ready} !== '0) begin
            miscompares++; $display("FAIL capt_rst_bus: got opcode=%b a=%h req_ready=%b, expected all 0", alu_opcode, alu_a, req_ready);
        end
        vectors++;
        if ({rsp_valid, rsp_out, rsp_branch_sel, rsp_err} !== {1'b0, 64'd0, 3'b111, 1'b0}) begin
            miscompares++; $display("FAIL capt_rst_rsp: got valid=%b out=%h sel=%b err=%b, expected 0 0 111 0",
                                    rsp_valid, rsp_out, rsp_branch_sel, rsp_err);
        end
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL discarded_rsp[%0d]: got valid=1, expected 0", n); end
        end
        expect_rsp(1, 64'd42, 3'b111, 1'b0);
        @(posedge clk); #1;
        issue(1, OP_ITYPE, 3'b000, 7'b0, 64'd30, 64'd12, 64'd0, t);
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_branch();
        test_alu_ops();
        test_backpressure();
        test_err();
        test_reset_in_capt();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL leftover: got %0d outstanding responses, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
